// File: rtl/resource_pool_lock_manager_pkg.sv
// Types and helpers shared by the pool lock manager and the issue controller.
// Request ports carry {valid, id} packed with valid as the MSB, laid out like rpl_req_t.
package resource_pool_lock_manager_pkg;

    localparam logic [1:0] PORT_IDLE = 2'd0;
    localparam logic [1:0] PORT_WAIT = 2'd1;
    localparam logic [1:0] PORT_HELD = 2'd2;

    localparam logic [0:0] UNIT_FREE = 1'b0;
    localparam logic [0:0] UNIT_HELD = 1'b1;

    typedef enum logic [1:0] {
        P_IDLE = PORT_IDLE,
        P_WAIT = PORT_WAIT,
        P_HELD = PORT_HELD
    } lock_port_state_e;

    typedef enum logic [0:0] {
        U_FREE = UNIT_FREE,
        U_HELD = UNIT_HELD
    } lock_unit_state_e;

    localparam int RPL_ID_WIDTH = 16;

    typedef struct packed {
        logic                    valid;
        logic [RPL_ID_WIDTH-1:0] id;
    } rpl_req_t;

    // a is older than b when (a - b) is negative in a width-bit wrapping space.
    // Callers zero-extend both IDs to 32 bits; bit width-1 of the 32-bit
    // difference equals the sign bit of the width-bit difference.
    function automatic logic id_older(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input int unsigned width);
        logic [31:0] diff;
        logic [31:0] shifted;
        diff    = a - b;
        shifted = diff >> (width - 1);
        return shifted[0];
    endfunction

endpackage

// File: rtl/resource_pool_lock_manager_oldest_rank_allocator.sv
// Combinational oldest-first allocator: ranks pending ports by wrap-aware age and
// maps rank k onto the k-th lowest-indexed free unit.
module oldest_rank_allocator
    import resource_pool_lock_manager_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int NUM_UNITS = 8,
    parameter int ID_WIDTH  = 16,
    parameter int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic [NUM_PORTS-1:0]               pending,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] ids,
    input  logic [NUM_UNITS-1:0]               free_mask,
    output logic [NUM_PORTS-1:0]               alloc,
    output logic [NUM_PORTS-1:0][UNIT_W-1:0]   alloc_unit
);

    localparam int CNT_W = $clog2(NUM_PORTS + NUM_UNITS + 1);

    logic [CNT_W-1:0]                 free_idx [NUM_UNITS];
    logic [NUM_PORTS-1:0]             cand;
    logic [NUM_PORTS-1:0][UNIT_W-1:0] target;

    always_comb begin
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            free_idx[u] = cnt;
            cnt         = cnt + CNT_W'(free_mask[u]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [CNT_W-1:0]  rank_val;
            logic              hit;
            logic [UNIT_W-1:0] sel;
            logic              clash;

            always_comb begin
                rank_val = '0;
                for (int q = 0; q < NUM_PORTS; q++) begin
                    if (pending[q] && q != gi) begin
                        if (id_older(32'(ids[q]), 32'(ids[gi]), ID_WIDTH) ||
                            (ids[q] == ids[gi] && q < gi)) begin
                            rank_val = rank_val + CNT_W'(1);
                        end
                    end
                end
            end

            // A rank at or beyond the free count finds no matching unit and stays pending.
            always_comb begin
                hit = 1'b0;
                sel = '0;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (free_mask[u] && free_idx[u] == rank_val) begin
                        hit = 1'b1;
                        sel = UNIT_W'(u);
                    end
                end
            end

            // Wrap-aware age is not transitive when IDs span more than half the
            // space; this guard keeps a unit from ever going to two ports at once.
            always_comb begin
                clash = 1'b0;
                for (int q = 0; q < gi; q++) begin
                    if (cand[q] && target[q] == sel) begin
                        clash = 1'b1;
                    end
                end
            end

            assign cand[gi]       = pending[gi] && hit;
            assign target[gi]     = sel;
            assign alloc[gi]      = cand[gi] && !clash;
            assign alloc_unit[gi] = sel;
        end
    endgenerate

endmodule

// File: rtl/resource_pool_lock_manager.sv
// Lease manager for a pool of identical units: per-port and per-unit state
// registers around the oldest-first allocator; all outputs decode registered state.
module resource_pool_lock_manager
    import resource_pool_lock_manager_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int NUM_UNITS = 8,
    parameter int ID_WIDTH  = 16,
    parameter int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               rollback,
    input  logic [NUM_PORTS-1:0][ID_WIDTH:0]   rpl_req,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [NUM_PORTS-1:0][UNIT_W-1:0]   grant_unit,
    output logic [NUM_UNITS-1:0]               unit_busy,
    output logic [NUM_UNITS-1:0][PORT_W-1:0]   unit_owner
);

    logic [NUM_PORTS-1:0]               req_valid;
    logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id;
    logic [NUM_PORTS-1:0]               release_port;
    logic [NUM_PORTS-1:0]               pending;
    logic [NUM_UNITS-1:0]               free_mask;
    logic [NUM_PORTS-1:0]               alloc;
    logic [NUM_PORTS-1:0][UNIT_W-1:0]   alloc_unit;

    oldest_rank_allocator #(
        .NUM_PORTS (NUM_PORTS),
        .NUM_UNITS (NUM_UNITS),
        .ID_WIDTH  (ID_WIDTH),
        .UNIT_W    (UNIT_W)
    ) u_alloc (
        .pending    (pending),
        .ids        (req_id),
        .free_mask  (free_mask),
        .alloc      (alloc),
        .alloc_unit (alloc_unit)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            lock_port_state_e  state_reg;
            lock_port_state_e  state_next;
            logic [ID_WIDTH-1:0] id_reg;
            logic [UNIT_W-1:0] unit_reg;
            logic              held;

            assign req_valid[gi] = rpl_req[gi][ID_WIDTH];
            assign req_id[gi]    = rpl_req[gi][ID_WIDTH-1:0];
            assign held          = (state_reg == P_HELD);

            // A port that releases this cycle competes again only from the next
            // cycle, so an ID change always shows one cycle of grant low.
            assign release_port[gi] = held && (!req_valid[gi] || req_id[gi] != id_reg);
            assign pending[gi]      = req_valid[gi] && !held;

            always_comb begin
                state_next = P_IDLE;
                if (alloc[gi]) begin
                    state_next = P_HELD;
                end else if (held && !release_port[gi]) begin
                    state_next = P_HELD;
                end else if (req_valid[gi]) begin
                    state_next = P_WAIT;
                end
            end

            always_ff @(posedge clk) begin
                if (reset || rollback) begin
                    state_reg <= P_IDLE;
                    id_reg    <= '0;
                    unit_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (alloc[gi]) begin
                        id_reg   <= req_id[gi];
                        unit_reg <= alloc_unit[gi];
                    end
                end
            end

            assign grant[gi]      = held;
            assign grant_unit[gi] = held ? unit_reg : '0;
        end

        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            lock_unit_state_e  state_reg;
            logic [PORT_W-1:0] owner_reg;
            logic              take;
            logic [PORT_W-1:0] taker;
            logic              busy;
            logic              releasing;

            always_comb begin
                take  = 1'b0;
                taker = '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (alloc[p] && alloc_unit[p] == UNIT_W'(gi)) begin
                        take  = 1'b1;
                        taker = PORT_W'(p);
                    end
                end
            end

            assign busy           = (state_reg == U_HELD);
            assign releasing      = busy && release_port[owner_reg];
            assign free_mask[gi]  = !busy || releasing;

            // A grant on a unit released this same cycle wins over the release.
            always_ff @(posedge clk) begin
                if (reset || rollback) begin
                    state_reg <= U_FREE;
                    owner_reg <= '0;
                end else if (take) begin
                    state_reg <= U_HELD;
                    owner_reg <= taker;
                end else if (releasing) begin
                    state_reg <= U_FREE;
                end
            end

            assign unit_busy[gi]  = busy;
            assign unit_owner[gi] = busy ? owner_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_resource_pool_lock_manager.sv
// Scoreboard bench: drives the same request pattern into 8-, 2- and 1-unit pools
// and checks each expected output on the cycle it is due.
module tb_resource_pool_lock_manager;

    localparam int D8 = 0;
    localparam int D2 = 1;
    localparam int D1 = 2;

    localparam int S_GRANT = 0;
    localparam int S_GUNIT = 1;
    localparam int S_BUSY  = 2;
    localparam int S_OWNER = 3;

    logic clk;
    logic reset;
    logic rollback;
    logic [7:0][16:0] req;

    logic [7:0]       grant_8;
    logic [7:0][2:0]  gunit_8;
    logic [7:0]       busy_8;
    logic [7:0][2:0]  owner_8;

    logic [7:0]       grant_2;
    logic [7:0][0:0]  gunit_2;
    logic [1:0]       busy_2;
    logic [1:0][2:0]  owner_2;

    logic [7:0]       grant_1;
    logic [7:0][0:0]  gunit_1;
    logic [0:0]       busy_1;
    logic [0:0][2:0]  owner_1;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int    due;
        int    dut;
        int    sig;
        int    idx;
        int    val;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    resource_pool_lock_manager #(.NUM_PORTS(8), .NUM_UNITS(8), .ID_WIDTH(16)) dut8 (
        .clk(clk), .reset(reset), .rollback(rollback), .rpl_req(req),
        .grant(grant_8), .grant_unit(gunit_8), .unit_busy(busy_8), .unit_owner(owner_8)
    );

    resource_pool_lock_manager #(.NUM_PORTS(8), .NUM_UNITS(2), .ID_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .rollback(rollback), .rpl_req(req),
        .grant(grant_2), .grant_unit(gunit_2), .unit_busy(busy_2), .unit_owner(owner_2)
    );

    resource_pool_lock_manager #(.NUM_PORTS(8), .NUM_UNITS(1), .ID_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .rollback(rollback), .rpl_req(req),
        .grant(grant_1), .grant_unit(gunit_1), .unit_busy(busy_1), .unit_owner(owner_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end else begin
            $display("txn %s: observed 0x%0h expected 0x%0h ok (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int observe(input int dut, input int sig, input int idx);
        int r;
        r = -1;
        case (dut)
            D8: case (sig)
                S_GRANT: r = int'(grant_8);
                S_GUNIT: r = int'(gunit_8[idx]);
                S_BUSY:  r = int'(busy_8);
                S_OWNER: r = int'(owner_8[idx]);
                default: r = -1;
            endcase
            D2: case (sig)
                S_GRANT: r = int'(grant_2);
                S_GUNIT: r = int'(gunit_2[idx]);
                S_BUSY:  r = int'(busy_2);
                S_OWNER: r = int'(owner_2[idx]);
                default: r = -1;
            endcase
            default: case (sig)
                S_GRANT: r = int'(grant_1);
                S_GUNIT: r = int'(gunit_1[idx]);
                S_BUSY:  r = int'(busy_1);
                S_OWNER: r = int'(owner_1[0]);
                default: r = -1;
            endcase
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].due == cyc) begin
                check_val(sb_q[i].tag, observe(sb_q[i].dut, sb_q[i].sig, sb_q[i].idx), sb_q[i].val);
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push(input int dly, input int dut, input int sig, input int idx,
                        input int val, input string tag);
        exp_t e;
        e.due = cyc + dly;
        e.dut = dut;
        e.sig = sig;
        e.idx = idx;
        e.val = val;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [15:0] id);
        req[p] = {v, id};
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rollback = 1'b0;
        req      = '0;
        push(1, D8, S_GRANT, 0, 0, "rst_grant8");
        push(1, D8, S_BUSY,  0, 0, "rst_busy8");
        push(1, D2, S_BUSY,  0, 0, "rst_busy2");
        push(1, D1, S_GRANT, 0, 0, "rst_grant1");
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rollback = 1'b0;
        req      = '0;
        step();
        step();

        // single request
        do_reset();
        set_req(3, 1'b1, 16'h0010);
        push(1, D8, S_GRANT, 0, 'h08, "single_grant");
        push(1, D8, S_GUNIT, 3, 0,    "single_gunit3");
        push(1, D8, S_BUSY,  0, 'h01, "single_busy");
        push(1, D8, S_OWNER, 0, 3,    "single_owner0");
        step();
        push(1, D8, S_GRANT, 0, 'h08, "single_hold");
        step();
        set_req(3, 1'b0, 16'h0010);
        push(1, D8, S_GRANT, 0, 0, "single_release");
        push(1, D8, S_BUSY,  0, 0, "single_release_busy");
        step();

        // oversubscription: ids 40,10,30,20 on ports 0..3
        do_reset();
        set_req(0, 1'b1, 16'd40);
        set_req(1, 1'b1, 16'd10);
        set_req(2, 1'b1, 16'd30);
        set_req(3, 1'b1, 16'd20);
        push(1, D2, S_GRANT, 0, 'h0A, "over_grant2");
        push(1, D2, S_GUNIT, 1, 0,    "over_gunit1");
        push(1, D2, S_GUNIT, 3, 1,    "over_gunit3");
        push(1, D2, S_OWNER, 0, 1,    "over_owner0");
        push(1, D2, S_OWNER, 1, 3,    "over_owner1");
        push(1, D2, S_BUSY,  0, 'h3,  "over_busy2");
        push(1, D8, S_GRANT, 0, 'h0F, "over_grant8");
        push(1, D8, S_GUNIT, 0, 3,    "over8_gunit0");
        push(1, D8, S_GUNIT, 2, 2,    "over8_gunit2");
        step();
        set_req(1, 1'b0, 16'd10);
        push(1, D2, S_GRANT, 0, 'h0C, "over_handoff_grant");
        push(1, D2, S_GUNIT, 2, 0,    "over_handoff_gunit2");
        push(1, D2, S_OWNER, 0, 2,    "over_handoff_owner0");
        step();

        // wrap-around on one unit
        do_reset();
        set_req(0, 1'b1, 16'hFFFE);
        set_req(1, 1'b1, 16'h0001);
        push(1, D1, S_GRANT, 0, 'h01, "wrap_grant");
        push(1, D1, S_GUNIT, 0, 0,    "wrap_gunit0");
        step();
        push(1, D1, S_GRANT, 0, 'h01, "wrap_hold");
        step();
        set_req(0, 1'b0, 16'hFFFE);
        push(1, D1, S_GRANT, 0, 'h02, "wrap_next");
        push(1, D1, S_GUNIT, 1, 0,    "wrap_gunit1");
        push(1, D1, S_OWNER, 0, 1,    "wrap_owner");
        step();

        // zero-bubble handoff
        do_reset();
        set_req(2, 1'b1, 16'd5);
        push(1, D1, S_GRANT, 0, 'h04, "hand_first");
        step();
        set_req(5, 1'b1, 16'd6);
        push(1, D1, S_GRANT, 0, 'h04, "hand_wait");
        step();
        set_req(2, 1'b0, 16'd5);
        push(1, D1, S_GRANT, 0, 'h20, "hand_grant");
        push(1, D1, S_GUNIT, 5, 0,    "hand_gunit5");
        push(1, D1, S_BUSY,  0, 1,    "hand_busy");
        push(1, D1, S_OWNER, 0, 5,    "hand_owner");
        step();

        // ID change while held
        do_reset();
        set_req(4, 1'b1, 16'd7);
        push(1, D1, S_GRANT, 0, 'h10, "idchg_first");
        step();
        set_req(4, 1'b1, 16'd9);
        push(1, D1, S_GRANT, 0, 0,    "idchg_drop");
        push(1, D1, S_BUSY,  0, 0,    "idchg_drop_busy");
        push(2, D1, S_GRANT, 0, 'h10, "idchg_regrant");
        push(2, D1, S_OWNER, 0, 4,    "idchg_owner");
        step();
        step();

        // rollback with all eight units held, then reset mid-lease
        do_reset();
        for (int p = 0; p < 8; p++) set_req(p, 1'b1, 16'(100 + p));
        push(1, D8, S_GRANT, 0, 'hFF, "rb_full_grant");
        push(1, D8, S_BUSY,  0, 'hFF, "rb_full_busy");
        step();
        rollback = 1'b1;
        push(1, D8, S_GRANT, 0, 0, "rb_grant");
        push(1, D8, S_BUSY,  0, 0, "rb_busy");
        push(1, D1, S_BUSY,  0, 0, "rb_busy1");
        step();
        rollback = 1'b0;
        push(1, D8, S_GRANT, 0, 'hFF, "rb_regrant");
        push(1, D8, S_OWNER, 5, 5,    "rb_owner5");
        push(1, D8, S_GUNIT, 7, 7,    "rb_gunit7");
        step();
        reset = 1'b1;
        push(1, D8, S_GRANT, 0, 0, "midrst_grant");
        push(1, D8, S_BUSY,  0, 0, "midrst_busy");
        push(1, D8, S_GUNIT, 7, 0, "midrst_gunit7");
        push(1, D8, S_OWNER, 7, 0, "midrst_owner7");
        push(1, D1, S_GRANT, 0, 0, "midrst_grant1");
        step();
        reset = 1'b0;
        req   = '0;
        step();
        step();

        check_val("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
